mvm_avalon_loader: RTL and testbench

MVM_AVALON_LOADER -- requirements
Module: mvm_avalon_loader

---
 rtl/mvm_pkg.sv | 17 +
 rtl/mvm_avalon_loader.sv | 122 ++++++++++++
 tb/tb_mvm_avalon_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiply datapath: geometry, word
// width and the loader FSM state encoding.
package mvm_pkg;

  localparam int MVM_N          = 8;
  localparam int MVM_DATA_WIDTH = 8;
  localparam int WORD_WIDTH     = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    UNPACK,
    DONE
  } state_t;

endpackage : mvm_pkg

// File: rtl/mvm_avalon_loader.sv
// Reads N+1 64-bit words over Avalon-MM and unpacks them byte by byte into
// N row FIFOs (matrix A) and one vector FIFO (B), one FIFO write per cycle.
module mvm_avalon_loader
  import mvm_pkg::*;
#(
  parameter int N          = MVM_N,
  parameter int DATA_WIDTH = MVM_DATA_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    CLOCK_50,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [WORD_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic [N-1:0]            a_wren_out,
  output logic [N*DATA_WIDTH-1:0] a_data_out,
  input  logic [N-1:0]            a_full_in,
  output logic                    b_wren_out,
  output logic [DATA_WIDTH-1:0]   b_data_out,
  input  logic                    b_full_in,
  output logic                    busy,
  output logic                    load_done
);

  localparam int BYTES      = WORD_WIDTH / DATA_WIDTH;
  localparam int BIDX_W     = $clog2(BYTES);
  localparam int WIDX_W     = $clog2(N + 1);
  localparam int ADDR_SHIFT = $clog2(WORD_WIDTH / 8);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(N);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [WIDX_W-1:0]       r_word_idx;
  logic [BIDX_W-1:0]       r_byte_idx;
  logic [WORD_WIDTH-1:0]   r_buf;

  logic [DATA_WIDTH-1:0]   w_byte;
  logic                    w_unpack;
  logic                    w_is_b;
  logic                    w_a_full;
  logic                    w_issue;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_unpack = (r_state == UNPACK);
    w_is_b   = (r_word_idx == LAST_WORD);
    w_byte   = r_buf[r_byte_idx*DATA_WIDTH +: DATA_WIDTH];
    w_a_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_word_idx == WIDX_W'(i)) w_a_full = a_full_in[i];
    end
    // A write issues only when its target FIFO can take it.
    w_issue = w_unpack && !(w_is_b ? b_full_in : w_a_full);
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = REQ;
      REQ:     if (!avm_waitrequest) w_next_state = WAIT;
      WAIT:    if (avm_readdatavalid) w_next_state = UNPACK;
      UNPACK:  if (w_issue && r_byte_idx == LAST_BYTE)
                 w_next_state = w_is_b ? DONE : REQ;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decode from state and counters only; read data reaches a FIFO
  // only after passing through r_buf.
  always_comb begin
    avm_read    = (r_state == REQ);
    avm_address = avm_read ? r_base + (ADDR_WIDTH'(r_word_idx) << ADDR_SHIFT) : '0;
    a_wren_out  = '0;
    a_data_out  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_unpack && !w_is_b && r_word_idx == WIDX_W'(i)) begin
        a_data_out[i*DATA_WIDTH +: DATA_WIDTH] = w_byte;
        a_wren_out[i]                          = !a_full_in[i];
      end
    end
    b_data_out = (w_unpack && w_is_b) ? w_byte : '0;
    b_wren_out = w_unpack && w_is_b && !b_full_in;
    busy       = (r_state != IDLE);
    load_done  = (r_state == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      // NOTE: the word buffer is a plain register, not RAM, so it resets too.
      r_buf      <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && start) begin
        r_base     <= base_addr;
        r_word_idx <= '0;
      end
      if (r_state == WAIT && avm_readdatavalid) begin
        r_buf      <= avm_readdata;
        r_byte_idx <= '0;
      end
      if (w_issue) begin
        r_byte_idx <= r_byte_idx + BIDX_W'(1);
        if (r_byte_idx == LAST_BYTE && !w_is_b) r_word_idx <= r_word_idx + WIDX_W'(1);
      end
    end
  end

endmodule : mvm_avalon_loader

// File: tb/tb_mvm_avalon_loader.sv
// Self-checking bench for mvm_avalon_loader: a one-outstanding Avalon slave
// with read latency 1, FIFO backpressure injection and a table of load cases.
module tb_mvm_avalon_loader;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 32;

  logic            CLOCK_50 = 1'b0;
  logic            rst_n    = 1'b0;
  logic            start    = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW-1:0]   avm_address;
  logic            avm_read;
  logic            avm_waitrequest = 1'b0;
  logic [63:0]     avm_readdata = '0;
  logic            avm_readdatavalid = 1'b0;
  logic [N-1:0]    a_wren_out;
  logic [N*DW-1:0] a_data_out;
  logic [N-1:0]    a_full_in = '0;
  logic            b_wren_out;
  logic [DW-1:0]   b_data_out;
  logic            b_full_in = 1'b0;
  logic            busy;
  logic            load_done;

  mvm_avalon_loader #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLOCK_50          (CLOCK_50),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .a_wren_out        (a_wren_out),
    .a_data_out        (a_data_out),
    .a_full_in         (a_full_in),
    .b_wren_out        (b_wren_out),
    .b_data_out        (b_data_out),
    .b_full_in         (b_full_in),
    .busy              (busy),
    .load_done         (load_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [AW-1:0] base;
    int            wait_len;   // waitrequest cycles on word 4
    int            stall_row;  // 0..N-1 = A row, N = B FIFO
    int            stall_len;  // full cycles after 3 writes into stall_row
    int            start_at;   // cycle of a one-cycle start pulse while busy
    int            spur_at;    // cycle of a spurious readdatavalid
    int            exp_done;   // cycle of load_done, counted from accepted start
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  // Environment knobs (written by the main process, read by the slave).
  logic [AW-1:0] cur_base  = '0;
  int            wait_len  = 0;
  int            stall_row = 0;
  int            stall_len = 0;
  logic          spur_req  = 1'b0;
  int            tgt_cnt   = 0;

  // Per-load observations (main process only).
  int log_q[$];
  int acc_reads, word0_reads, hold_cnt, lane_err;

  // Slave-private state.
  int            full_cnt = 0;
  int            wcnt     = 0;
  logic          rd_acc   = 1'b0;
  logic [AW-1:0] rd_addr  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [AW-1:0] addr);
    logic [63:0] d;
    int w;
    w = int'((addr - cur_base) >> 3);
    for (int j = 0; j < 8; j++)
      d[8*j +: 8] = (w < N) ? 8'(8*w + j) : ((w == N) ? 8'(j + 1) : 8'hEE);
    return d;
  endfunction

  function automatic logic any_out();
    return avm_read | (|avm_address) | (|a_wren_out) | (|a_data_out) |
           b_wren_out | (|b_data_out) | busy | load_done;
  endfunction

  // Avalon slave and FIFO-full generator; updates just after each rising edge.
  always begin
    @(posedge CLOCK_50);
    #1;
    if (!busy) begin
      full_cnt = 0;
      wcnt     = 0;
    end
    a_full_in = '0;
    b_full_in = 1'b0;
    if (stall_len > 0 && tgt_cnt == 3 && full_cnt < stall_len) begin
      if (stall_row == N) b_full_in = 1'b1;
      else                a_full_in = N'(1) << stall_row;
      full_cnt++;
    end
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    if (rd_acc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(rd_addr);
    end else if (spur_req) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 64'hA5A5_5A5A_C3C3_3C3C;
    end
    if (avm_read && avm_address == cur_base + 32'h20 && wcnt < wait_len) begin
      avm_waitrequest = 1'b1;
      wcnt++;
    end else begin
      avm_waitrequest = 1'b0;
    end
    rd_acc  = avm_read && !avm_waitrequest;
    rd_addr = avm_address;
  end

  task automatic clear_obs();
    log_q.delete();
    acc_reads   = 0;
    word0_reads = 0;
    hold_cnt    = 0;
    lane_err    = 0;
    tgt_cnt     = 0;
  endtask

  // Watches one load cycle by cycle until load_done or the cycle budget ends.
  task automatic collect(input vec_t v, input int t_first, output int done_t,
                         output logic [AW-1:0] first_addr);
    bit first_seen = 0;
    int nw;
    done_t     = -1;
    first_addr = '0;
    for (int t = t_first; t <= 400; t++) begin
      @(negedge CLOCK_50);
      if (t == v.start_at) start = 1'b1;
      else if (t == v.start_at + 1) start = 1'b0;
      spur_req = (t == v.spur_at - 1);
      if (avm_read && !avm_waitrequest) begin
        acc_reads++;
        if (avm_address == v.base) word0_reads++;
        if (!first_seen) begin
          first_addr = avm_address;
          first_seen = 1;
        end
      end
      if (avm_read && avm_address == v.base + 32'h20) hold_cnt++;
      nw = 0;
      for (int i = 0; i < N; i++) begin
        if (a_wren_out[i]) begin
          log_q.push_back(i*256 + int'(a_data_out[i*DW +: DW]));
          nw++;
          if (a_full_in[i]) lane_err++;
        end else if ((|a_wren_out) && a_data_out[i*DW +: DW] != '0) begin
          lane_err++;
        end
      end
      if (b_wren_out) begin
        log_q.push_back(N*256 + int'(b_data_out));
        nw++;
        if (b_full_in) lane_err++;
      end
      if (nw > 1) lane_err++;
      if (stall_row == N) begin
        if (b_wren_out) tgt_cnt++;
      end else if (a_wren_out[stall_row]) begin
        tgt_cnt++;
      end
      if (load_done) begin
        done_t = t;
        break;
      end
    end
    spur_req = 1'b0;
  endtask

  task automatic check_log(input string name);
    int bad = 0;
    int row, exp;
    if (log_q.size() != (N + 1) * 8) begin
      bad = 1000 + log_q.size();
    end else begin
      for (int k = 0; k < (N + 1) * 8; k++) begin
        row = k / 8;
        exp = row * 256 + ((row < N) ? (8*row + k % 8) : (k % 8 + 1));
        if (log_q[k] != exp) bad++;
      end
    end
    check(name, 64'(bad), 64'd0);
  endtask

  task automatic do_load(input string tag, input vec_t v, input bit hold);
    int            done_t;
    logic [AW-1:0] first_addr;
    cur_base  = v.base;
    base_addr = v.base;
    wait_len  = v.wait_len;
    stall_row = v.stall_row;
    stall_len = v.stall_len;
    clear_obs();
    @(negedge CLOCK_50);
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    if (!hold) start = 1'b0;
    collect(v, 1, done_t, first_addr);
    check({tag, "_done_cycle"}, 64'(done_t), 64'(v.exp_done));
    check_log({tag, "_fifo_data"});
    check({tag, "_first_addr"}, 64'(first_addr), 64'(v.base));
    check({tag, "_word0_reads"}, 64'(word0_reads), 64'd1);
    check({tag, "_total_reads"}, 64'(acc_reads), 64'(N + 1));
    check({tag, "_req_hold"}, 64'(hold_cnt), 64'(v.wait_len + 1));
    check({tag, "_lane_errs"}, 64'(lane_err), 64'd0);
    @(negedge CLOCK_50);
    check({tag, "_done_pulse"}, {62'd0, load_done, busy}, 64'd0);
  endtask

  initial begin
    int            done_t;
    logic [AW-1:0] first_addr;
    vec_t          v;

    //          base      wait row stall start spur done
    vecs[0] = '{32'h100,  0,   0,  0,    -1,   -1,  91};  // nominal
    vecs[1] = '{32'h100,  3,   0,  0,    -1,   -1,  94};  // waitrequest on word 4
    vecs[2] = '{32'h100,  0,   2,  5,    -1,   -1,  96};  // A row 2 backpressure
    vecs[3] = '{32'h100,  0,   0,  0,    35,   -1,  91};  // start pulse in word 3
    vecs[4] = '{32'h2000, 0,   0,  0,    -1,   14,  91};  // spurious valid in UNPACK
    vecs[5] = '{32'h100,  0,   N,  2,    -1,   -1,  93};  // B FIFO backpressure

    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", 64'(any_out()), 64'd0);
    rst_n = 1'b1;
    @(negedge CLOCK_50);

    // Spurious readdatavalid while idle must not start anything.
    spur_req = 1'b1;
    @(negedge CLOCK_50);
    spur_req = 1'b0;
    check("idle_spurious", {61'd0, busy, |a_wren_out, b_wren_out}, 64'd0);

    for (int i = 0; i < 6; i++) do_load($sformatf("v%0d", i), vecs[i], 1'b0);

    // Start held high: ignored while busy, then a fresh load from word 0.
    v = vecs[0];
    do_load("hold", v, 1'b1);
    @(negedge CLOCK_50);
    check("hold_restart", {31'd0, avm_read, avm_address}, {31'd0, 1'b1, v.base});
    start = 1'b0;
    clear_obs();
    collect(v, 2, done_t, first_addr);
    check("hold_second_done", 64'(done_t), 64'd91);
    check_log("hold_second_data");

    // Reset during WAIT of word 5, then reload from a new base.
    cur_base  = v.base;
    base_addr = v.base;
    @(negedge CLOCK_50);
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    repeat (52) @(negedge CLOCK_50);
    check("pre_reset_wait", {62'd0, busy, avm_read}, 64'd2);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'(any_out()), 64'd0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    v.base = 32'h4000;
    do_load("after_reset", v, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mvm_avalon_loader
